// File: rtl/difftest_commit_stage_pkg.sv
// Shared constants, types and the skip classifier for the difftest commit stage.
package difftest_commit_stage_pkg;

    localparam int PKG_XLEN = 64;
    localparam int PKG_ILEN = 32;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0]  OPC_PUTCH  = 7'h7b;
    localparam logic [11:0] CSR_MCYCLE = 12'hB00;
    localparam logic [31:0] TRAP_INST  = 32'h0000_006b;
    localparam logic [31:0] IRQ_CODE   = 32'd7;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_TRAPPED = 1'b1
    } state_t;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_ILEN-1:0] inst;
        logic                wen;
        logic [7:0]          wdest;
        logic [PKG_XLEN-1:0] wdata;
        logic                skip;
    } commit_entry_t;

    // Instructions whose effects the reference model cannot reproduce:
    // putch, mcycle reads and accesses to device space below main memory.
    function automatic logic calc_skip(input logic [PKG_ILEN-1:0] inst,
                                       input logic [PKG_XLEN-1:0] mem_addr,
                                       input logic [PKG_XLEN-1:0] mmio_base);
        logic skip;
        case (inst[6:0])
            OPC_PUTCH:           skip = 1'b1;
            OPC_SYSTEM:          skip = (inst[31:20] == CSR_MCYCLE);
            OPC_LOAD, OPC_STORE: skip = (mem_addr < mmio_base);
            default:             skip = 1'b0;
        endcase
        return skip;
    endfunction

endpackage

// File: rtl/commit_fifo2.sv
// Two-entry synchronous FIFO holding commit entries stalled behind an interrupt.
module commit_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [2];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_pop_s  = pop && (count_r != 2'd0);
    assign do_push_s = push && ((count_r != 2'd2) || do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r];
    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);

    // Entry storage; contents of empty slots are never observed.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; a flush drops every held entry.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/difftest_commit_stage_chk.sv
// Checker for the commit stage: the FIFO must never overflow.
module difftest_commit_stage_chk (
    input logic clock,
    input logic reset,
    input logic push,
    input logic pop,
    input logic full
);

    // Interrupt spacing bounds occupancy; a push onto a full FIFO loses a commit.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && full && !pop));

endmodule

// File: rtl/difftest_commit_stage.sv
// Retirement-side commit formatter feeding the difftest commit, trap and event probes.
module difftest_commit_stage
    import difftest_commit_stage_pkg::*;
#(
    parameter int                  XLEN      = PKG_XLEN,
    parameter int                  ILEN      = PKG_ILEN,
    parameter logic [PKG_XLEN-1:0] MMIO_BASE = 64'h8000_0000,
    parameter int                  IRQ_DELAY = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_pc,
    input  logic [ILEN-1:0] wb_inst,
    input  logic            wb_rd_wen,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic [XLEN-1:0] wb_mem_addr,
    input  logic [XLEN-1:0] a0_value,
    input  logic            irq_take,
    input  logic [XLEN-1:0] irq_pc,
    input  logic [ILEN-1:0] irq_inst,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [ILEN-1:0] commit_instr,
    output logic            commit_skip,
    output logic            commit_wen,
    output logic [7:0]      commit_wdest,
    output logic [XLEN-1:0] commit_wdata,
    output logic            trap_valid,
    output logic [7:0]      trap_code,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] cycle_cnt,
    output logic [XLEN-1:0] instr_cnt,
    output logic [31:0]     intr_no,
    output logic [XLEN-1:0] intr_pc,
    output logic [ILEN-1:0] intr_inst
);

    localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    state_t          state_r;
    commit_entry_t   commit_r;
    logic            commit_valid_r;
    logic            trap_valid_r;
    logic [7:0]      trap_code_r;
    logic [XLEN-1:0] trap_pc_r;
    logic [XLEN-1:0] cycle_cnt_r;
    logic [XLEN-1:0] instr_cnt_r;
    logic [31:0]     irq_no_r   [IRQ_DELAY];
    logic [XLEN-1:0] irq_pc_r   [IRQ_DELAY];
    logic [ILEN-1:0] irq_inst_r [IRQ_DELAY];

    commit_entry_t   in_entry_s;
    commit_entry_t   fifo_head_s;
    commit_entry_t   cand_s;
    logic            cand_valid_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            run_s;
    logic            trap_now_s;
    logic            wb_accept_s;
    logic            emit_ok_s;
    logic            emit_s;
    logic            push_s;
    logic            pop_s;
    logic [31:0]     intr_next_no_s;

    // The interrupt code that will be presented next cycle decides whether a commit may go out.
    generate
        if (IRQ_DELAY == 1) begin : g_irq_d1
            assign intr_next_no_s = irq_take ? IRQ_CODE : 32'd0;
        end else begin : g_irq_dn
            assign intr_next_no_s = irq_no_r[IRQ_DELAY-2];
        end
    endgenerate

    assign run_s       = (state_r == ST_RUN);
    assign trap_now_s  = commit_valid_r && (commit_r.inst == TRAP_INST);
    assign wb_accept_s = wb_valid && run_s && !trap_now_s;
    assign emit_ok_s   = run_s && !trap_now_s && (intr_next_no_s == 32'd0);
    assign emit_s      = emit_ok_s && cand_valid_s;
    assign pop_s       = emit_s && !fifo_empty_s;
    // An empty FIFO with a free output slot lets the new entry bypass storage.
    assign push_s      = wb_accept_s && !(fifo_empty_s && emit_ok_s);

    // Format the retiring instruction into a commit entry, classifying skip now.
    always_comb begin
        in_entry_s       = '0;
        in_entry_s.pc    = wb_pc;
        in_entry_s.inst  = wb_inst;
        in_entry_s.wen   = wb_rd_wen;
        in_entry_s.wdest = {3'b000, wb_rd_addr};
        in_entry_s.wdata = wb_rd_data;
        in_entry_s.skip  = calc_skip(wb_inst, wb_mem_addr, MMIO_BASE);
    end

    // Oldest pending entry wins; otherwise the entry arriving this cycle.
    always_comb begin
        cand_s       = in_entry_s;
        cand_valid_s = 1'b0;
        if (!fifo_empty_s) begin
            cand_s       = fifo_head_s;
            cand_valid_s = 1'b1;
        end else begin
            cand_s       = in_entry_s;
            cand_valid_s = wb_accept_s;
        end
    end

    commit_fifo2 #(
        .WIDTH ($bits(commit_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (trap_now_s),
        .push      (push_s),
        .push_data (in_entry_s),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    difftest_commit_stage_chk u_chk (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .full  (fifo_full_s)
    );

    // Commit and trap registers, counters and the RUN/TRAPPED state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_RUN;
            commit_r       <= '0;
            commit_valid_r <= 1'b0;
            trap_valid_r   <= 1'b0;
            trap_code_r    <= 8'd0;
            trap_pc_r      <= '0;
            cycle_cnt_r    <= '0;
            instr_cnt_r    <= '0;
        end else begin
            commit_valid_r <= emit_s;
            if (run_s) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            end
            if (emit_s) begin
                commit_r    <= cand_s;
                instr_cnt_r <= instr_cnt_r + CNT_ONE;
                if (cand_s.inst == TRAP_INST) begin
                    trap_valid_r <= 1'b1;
                    trap_code_r  <= a0_value[7:0];
                    trap_pc_r    <= cand_s.pc;
                end
            end
            if (trap_now_s) begin
                state_r <= ST_TRAPPED;
            end
        end
    end

    // Interrupt alignment pipe; frozen once trapped so the last event stays visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < IRQ_DELAY; i++) begin
                irq_no_r[i]   <= 32'd0;
                irq_pc_r[i]   <= '0;
                irq_inst_r[i] <= '0;
            end
        end else if (run_s) begin
            irq_no_r[0]   <= irq_take ? IRQ_CODE : 32'd0;
            irq_pc_r[0]   <= irq_take ? irq_pc : '0;
            irq_inst_r[0] <= irq_take ? irq_inst : '0;
            for (int i = 1; i < IRQ_DELAY; i++) begin
                irq_no_r[i]   <= irq_no_r[i-1];
                irq_pc_r[i]   <= irq_pc_r[i-1];
                irq_inst_r[i] <= irq_inst_r[i-1];
            end
        end
    end

    assign commit_valid = commit_valid_r;
    assign commit_pc    = commit_r.pc;
    assign commit_instr = commit_r.inst;
    assign commit_skip  = commit_r.skip;
    assign commit_wen   = commit_r.wen;
    assign commit_wdest = commit_r.wdest;
    assign commit_wdata = commit_r.wdata;
    assign trap_valid   = trap_valid_r;
    assign trap_code    = trap_code_r;
    assign trap_pc      = trap_pc_r;
    assign cycle_cnt    = cycle_cnt_r;
    assign instr_cnt    = instr_cnt_r;
    assign intr_no      = irq_no_r[IRQ_DELAY-1];
    assign intr_pc      = irq_pc_r[IRQ_DELAY-1];
    assign intr_inst    = irq_inst_r[IRQ_DELAY-1];

endmodule

// File: tb/tb_difftest_commit_stage.sv
// Self-checking bench for difftest_commit_stage: vector table plus scoreboard.
module tb_difftest_commit_stage;

    localparam int D = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [31:0] wb_inst;
    logic        wb_rd_wen;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_rd_data;
    logic [63:0] wb_mem_addr;
    logic [63:0] a0_value;
    logic        irq_take;
    logic [63:0] irq_pc;
    logic [31:0] irq_inst;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_instr;
    logic        commit_skip;
    logic        commit_wen;
    logic [7:0]  commit_wdest;
    logic [63:0] commit_wdata;
    logic        trap_valid;
    logic [7:0]  trap_code;
    logic [63:0] trap_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instr_cnt;
    logic [31:0] intr_no;
    logic [63:0] intr_pc;
    logic [31:0] intr_inst;

    difftest_commit_stage dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .wb_rd_wen(wb_rd_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .wb_mem_addr(wb_mem_addr), .a0_value(a0_value),
        .irq_take(irq_take), .irq_pc(irq_pc), .irq_inst(irq_inst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_skip(commit_skip), .commit_wen(commit_wen), .commit_wdest(commit_wdest),
        .commit_wdata(commit_wdata), .trap_valid(trap_valid), .trap_code(trap_code),
        .trap_pc(trap_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
        .intr_no(intr_no), .intr_pc(intr_pc), .intr_inst(intr_inst)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        skip;
    } exp_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [63:0] maddr;
        logic        skip;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          n_vec = 0;
    int          n_bad = 0;
    int          tick_no = 0;
    int          irq_due = -1;
    logic [63:0] irq_pc_m;
    logic [31:0] irq_inst_m;
    logic [63:0] exp_cyc = 64'd0;
    logic [63:0] exp_icnt = 64'd0;
    bit          trapped_m = 1'b0;
    bit          trap_cycle_m = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, tick_no);
        end
    endtask

    task automatic idle();
        wb_valid = 1'b0;
        irq_take = 1'b0;
    endtask

    task automatic drive_wb(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                            input logic [4:0] rd, input logic [63:0] data,
                            input logic [63:0] maddr, input logic skip, input bit expect_commit);
        exp_t e;
        wb_valid = 1'b1; wb_pc = pc; wb_inst = inst; wb_rd_wen = wen;
        wb_rd_addr = rd; wb_rd_data = data; wb_mem_addr = maddr;
        if (expect_commit) begin
            e.pc = pc; e.inst = inst; e.wen = wen; e.rd = rd; e.data = data; e.skip = skip;
            sb.push_back(e);
        end
    endtask

    task automatic drive_irq(input logic [63:0] pc, input logic [31:0] inst);
        irq_take = 1'b1; irq_pc = pc; irq_inst = inst;
        irq_due = tick_no + D;
        irq_pc_m = pc; irq_inst_m = inst;
    endtask

    // One clock: advance the model, then compare every output against it.
    task automatic tick();
        bit   in_reset, inc_ok, went_trap;
        exp_t e;
        in_reset  = reset;
        inc_ok    = !reset && !trapped_m;
        went_trap = trap_cycle_m;
        @(posedge clock);
        #1;
        tick_no++;
        if (in_reset) begin
            sb.delete();
            exp_cyc = 64'd0; exp_icnt = 64'd0;
            trapped_m = 1'b0; trap_cycle_m = 1'b0; irq_due = -1;
        end else begin
            if (inc_ok) exp_cyc++;
            if (went_trap) trapped_m = 1'b1;
            trap_cycle_m = 1'b0;
            if (commit_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_commit", {63'd0, commit_valid}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    exp_icnt++;
                    chk("commit_pc", commit_pc, e.pc);
                    chk("commit_instr", {32'd0, commit_instr}, {32'd0, e.inst});
                    chk("commit_skip", {63'd0, commit_skip}, {63'd0, e.skip});
                    chk("commit_wen", {63'd0, commit_wen}, {63'd0, e.wen});
                    chk("commit_wdest", {56'd0, commit_wdest}, {59'd0, e.rd});
                    chk("commit_wdata", commit_wdata, e.data);
                    if (e.inst == 32'h0000_006b) trap_cycle_m = 1'b1;
                end
            end
            if (tick_no == irq_due) begin
                chk("intr_no", {32'd0, intr_no}, 64'd7);
                chk("intr_pc", intr_pc, irq_pc_m);
                chk("intr_inst", {32'd0, intr_inst}, {32'd0, irq_inst_m});
                chk("commit_in_intr_cycle", {63'd0, commit_valid}, 64'd0);
            end else begin
                chk("intr_no_idle", {32'd0, intr_no}, 64'd0);
            end
            chk("cycle_cnt", cycle_cnt, exp_cyc);
            chk("instr_cnt", instr_cnt, exp_icnt);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [63:0] acc;
        acc = {63'd0, commit_valid} | commit_pc | {32'd0, commit_instr} | {63'd0, commit_skip}
            | {63'd0, commit_wen} | {56'd0, commit_wdest} | commit_wdata | {63'd0, trap_valid}
            | {56'd0, trap_code} | trap_pc | {32'd0, intr_no} | intr_pc | {32'd0, intr_inst};
        chk({tag, "_outputs_or"}, acc, 64'd0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
        chk({tag, "_instr_cnt"}, instr_cnt, 64'd0);
        chk({tag, "_commit_valid"}, {63'd0, commit_valid}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{64'h8000_0000, 32'h0010_0093, 1'b1, 5'd1,  64'd1,      64'h0,         1'b0};
        vecs[1] = '{64'h8000_0004, 32'h0000_2503, 1'b1, 5'd10, 64'h1234,   64'h0200_BFF8, 1'b1};
        vecs[2] = '{64'h8000_0008, 32'h00A0_2023, 1'b0, 5'd0,  64'd0,      64'h8000_1000, 1'b0};
        vecs[3] = '{64'h8000_000C, 32'hB000_2573, 1'b1, 5'd10, 64'h55,     64'h0,         1'b1};
        vecs[4] = '{64'h8000_0010, 32'h0000_007b, 1'b0, 5'd0,  64'd0,      64'h0,         1'b1};
        vecs[5] = '{64'h8000_0014, 32'hB020_2573, 1'b1, 5'd10, 64'd7,      64'h0,         1'b0};
        vecs[6] = '{64'h8000_0018, 32'h0000_2503, 1'b1, 5'd10, 64'hBEEF,   64'h8000_0000, 1'b0};
        vecs[7] = '{64'h8000_001C, 32'h00A0_0023, 1'b0, 5'd0,  64'd0,      64'h7FFF_FFFF, 1'b1};

        reset = 1'b1; a0_value = 64'd0;
        wb_pc = 64'd0; wb_inst = 32'd0; wb_rd_wen = 1'b0; wb_rd_addr = 5'd0;
        wb_rd_data = 64'd0; wb_mem_addr = 64'd0; irq_pc = 64'd0; irq_inst = 32'd0;
        idle();
        tick(); tick();
        check_zero("reset");
        reset = 1'b0;

        // Table: one retirement per cycle, each must appear exactly one cycle later.
        for (int i = 0; i < 8; i++) begin
            drive_wb(vecs[i].pc, vecs[i].inst, vecs[i].wen, vecs[i].rd, vecs[i].data,
                     vecs[i].maddr, vecs[i].skip, 1'b1);
            tick();
            chk($sformatf("vec%0d_latency", i), 64'(sb.size()), 64'd0);
        end
        idle(); tick();

        // Ten back-to-back retirements from a fresh reset.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_wb(64'h8000_1000 + 64'(4 * i), 32'h0010_0093, 1'b1, 5'd1, 64'(i), 64'h0, 1'b0, 1'b1);
            tick();
            chk("b2b_occupancy", 64'(sb.size()), 64'd0);
        end
        idle(); tick();
        chk("instr_cnt_10", instr_cnt, 64'd10);

        // Interrupt collision: commits at t+2 and t+3 slip past the t+3 event.
        drive_irq(64'h8000_2000, 32'h0000_0013);
        tick(); idle(); tick();
        drive_wb(64'h8000_2100, 32'h0020_0113, 1'b1, 5'd2, 64'hA, 64'h0, 1'b0, 1'b1);
        tick();
        chk("collision_blocked", {63'd0, commit_valid}, 64'd0);
        chk("collision_intr", {32'd0, intr_no}, 64'd7);
        drive_wb(64'h8000_2104, 32'h0030_0193, 1'b1, 5'd3, 64'hB, 64'h0, 1'b0, 1'b1);
        tick();
        chk("collision_first", commit_pc, 64'h8000_2100);
        idle(); tick();
        chk("collision_second", commit_pc, 64'h8000_2104);
        tick();
        chk("collision_drained", 64'(sb.size()), 64'd0);

        // Reset while entries are pending: nothing stale may surface afterwards.
        drive_irq(64'h8000_2200, 32'h0000_0013);
        tick(); idle(); tick();
        drive_wb(64'h8000_2300, 32'h0010_0093, 1'b1, 5'd1, 64'h1, 64'h0, 1'b0, 1'b1);
        tick();
        drive_wb(64'h8000_2304, 32'h0010_0093, 1'b1, 5'd1, 64'h2, 64'h0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check_zero("midreset");
        reset = 1'b0; idle();
        for (int i = 0; i < 4; i++) tick();

        // Trap with a0=0; later retirements and the cycle counter freeze.
        a0_value = 64'd0;
        drive_wb(64'h8000_3000, 32'h0000_006b, 1'b0, 5'd0, 64'd0, 64'h0, 1'b0, 1'b1);
        tick();
        chk("trap1_valid", {63'd0, trap_valid}, 64'd1);
        chk("trap1_code", {56'd0, trap_code}, 64'd0);
        chk("trap1_pc", trap_pc, 64'h8000_3000);
        drive_wb(64'h8000_3004, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 64'h0, 1'b0, 1'b0);
        tick(); tick(); tick();
        idle(); tick();
        chk("trap1_held", {63'd0, trap_valid}, 64'd1);

        // Trap stalled behind an interrupt, with a younger entry queued behind it.
        reset = 1'b1; idle(); tick(); reset = 1'b0;
        a0_value = 64'h1234_5678_9ABC_DEAB;
        drive_irq(64'h8000_4400, 32'h0000_0013);
        tick(); idle(); tick();
        drive_wb(64'h8000_4000, 32'h0000_006b, 1'b0, 5'd0, 64'd0, 64'h0, 1'b0, 1'b1);
        tick();
        drive_wb(64'h8000_4004, 32'h0010_0093, 1'b1, 5'd1, 64'd9, 64'h0, 1'b0, 1'b0);
        tick();
        chk("trap2_valid", {63'd0, trap_valid}, 64'd1);
        chk("trap2_code", {56'd0, trap_code}, 64'hAB);
        chk("trap2_pc", trap_pc, 64'h8000_4000);
        drive_wb(64'h8000_4008, 32'h0010_0093, 1'b1, 5'd1, 64'd8, 64'h0, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("trap2_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
